debounce_button: RTL and testbench
==================================

DEBOUNCE_BUTTON -- requirements
Module: debounce_button

Interface
REQ-001 The block SHALL have parameter STABLE_SAMPLES, default 4, meaning the number of consecutive equal tick-samples needed to accept a level change (legal 2..15).
REQ-002 The block SHALL have parameter HOLD_TICKS, default 250, meaning the number of ticks in PRESSED before held asserts (legal 1..1023).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means button_raw=0 is pressed.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic SHALL be on its posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port tick, input, 1 bit: sample enable, a one-clk_in-cycle pulse from the debounce clock divider that is synchronous to clk_in.
REQ-007 The block SHALL have port button_raw, input, 1 bit: asynchronous mechanical key input.
REQ-008 The block SHALL have port button_level, output, 1 bit: debounced pressed level, 1 meaning pressed.
REQ-009 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on an accepted press.
REQ-010 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on an accepted release.
REQ-011 The block SHALL have port held, output, 1 bit: long-press indication.

Function
REQ-012 The block SHALL pass button_raw through a 2-flop synchronizer, then normalize it by ACTIVE_LOW to pressed_s (1 meaning pressed).
REQ-013 The block SHALL sample pressed_s only on clk_in edges where tick=1; all other cycles SHALL leave the state and counters unchanged, apart from pulse clearing.
REQ-014 The FSM SHALL have the states RELEASED, CONFIRM_PRESS, PRESSED and CONFIRM_RELEASE, with a 4-bit sample counter cnt.
REQ-015 RELEASED: on tick with pressed_s=1, the FSM SHALL go to CONFIRM_PRESS with cnt=1; on tick with pressed_s=0, it SHALL stay in RELEASED.
REQ-016 CONFIRM_PRESS: on tick with pressed_s=1 and cnt+1==STABLE_SAMPLES, the FSM SHALL go to PRESSED; otherwise on tick with pressed_s=1, cnt SHALL increment.
REQ-017 CONFIRM_PRESS: on tick with pressed_s=0, the FSM SHALL return to RELEASED with cnt=0.
REQ-018 PRESSED and CONFIRM_RELEASE SHALL mirror RELEASED and CONFIRM_PRESS with the polarity inverted.
REQ-019 On entry to PRESSED from CONFIRM_PRESS, in the same edge: button_level SHALL become 1, press_pulse SHALL be 1 for exactly one cycle, cnt SHALL clear and hold_cnt SHALL clear.
REQ-020 On entry to RELEASED from CONFIRM_RELEASE, in the same edge: button_level SHALL become 0, held SHALL become 0, release_pulse SHALL be 1 for exactly one cycle, and cnt SHALL clear.
REQ-021 A return from CONFIRM_RELEASE to PRESSED (bounce) SHALL NOT generate a pulse and SHALL NOT clear hold_cnt.
REQ-022 hold_cnt (10 bits) SHALL increment on each tick while in PRESSED or CONFIRM_RELEASE and SHALL saturate at HOLD_TICKS.
REQ-023 held SHALL set on the edge where hold_cnt reaches HOLD_TICKS and SHALL remain 1 until an accepted release.
REQ-024 button_level SHALL be 1 in PRESSED and CONFIRM_RELEASE, and 0 in RELEASED and CONFIRM_PRESS.
REQ-025 press_pulse and release_pulse SHALL never be 1 in the same cycle, and each SHALL be followed by at least STABLE_SAMPLES ticks before the opposite pulse.
REQ-026 If tick is held high continuously, the block SHALL sample every cycle and remain correct.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 When reset=0, asynchronously: the FSM SHALL go to RELEASED, cnt=0, hold_cnt=0, both synchronizer flops SHALL load the not-pressed level, and button_level, press_pulse, release_pulse and held SHALL all be 0.
REQ-029 A reset asserted mid-operation, including in PRESSED with held=1, SHALL return all outputs to 0 immediately without emitting release_pulse.
REQ-030 After reset deasserts with the key already pressed, the block SHALL need STABLE_SAMPLES ticks before press_pulse.

Verification
REQ-031 Defaults, tick every 10 cycles, button_raw 1->0 held steady -> press_pulse on the edge of the 4th tick after the synchronized change, one cycle wide, and button_level=1.
REQ-032 Bounce: pressed for 3 ticks, released for 1 tick, then pressed for 4 ticks -> exactly one press_pulse, at the 4th tick of the final run.
REQ-033 Press held for 250 ticks after acceptance -> held=1 at the 250th tick; release for 4 ticks -> release_pulse with held=0 and button_level=0 on the same edge.
REQ-034 In PRESSED with hold_cnt=100, release for 2 ticks then press again -> no pulses, and held still asserts at the 250th PRESSED-domain tick.
REQ-035 Reset pulsed low while held=1 -> all outputs 0 within the same cycle, no release_pulse; with the key kept pressed, press_pulse follows 4 ticks after reset is released.
REQ-036 tick tied to 1, with a button_raw glitch of 3 cycles -> no pulse; a clean press of 6 cycles -> one press_pulse.

Source files
------------

// File: rtl/debounce_button.sv
// Push-button debouncer: 2-flop synchronizer, tick-sampled confirm FSM,
// registered level/press/release strobes and a saturating long-press detector.
module debounce_button #(
  parameter int STABLE_SAMPLES = 4,
  parameter int HOLD_TICKS     = 250,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  input  logic       button_raw,
  output logic       button_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_RELEASED        = 2'd0,
    S_CONFIRM_PRESS   = 2'd1,
    S_PRESSED         = 2'd2,
    S_CONFIRM_RELEASE = 2'd3
  } state_t;

  // Raw level that means "not pressed"; the synchronizer resets to it.
  localparam logic       IDLE_LEVEL = ACTIVE_LOW;
  localparam logic [3:0] STABLE_N   = 4'(STABLE_SAMPLES);
  localparam logic [9:0] HOLD_N     = 10'(HOLD_TICKS);

  logic       sync_q1;
  logic       sync_q2;
  logic       pressed_s;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [9:0] hold_cnt_q;
  logic [9:0] hold_cnt_d;

  logic       accept_press;
  logic       accept_release;
  logic       hold_run;
  logic       hold_reached;

  logic       level_d;
  logic       press_d;
  logic       release_d;
  logic       held_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q1 <= IDLE_LEVEL;
      sync_q2 <= IDLE_LEVEL;
    end else begin
      sync_q1 <= button_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed_s = sync_q2 ^ ACTIVE_LOW;

  // State register: FSM, counters and all outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RELEASED;
      cnt_q         <= 4'd0;
      hold_cnt_q    <= 10'd0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      button_level  <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      held          <= held_d;
    end
  end

  // Next-state logic: only tick cycles move the FSM or its sample counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        S_RELEASED: begin
          if (pressed_s) begin
            state_d = S_CONFIRM_PRESS;
            cnt_d   = 4'd1;
          end
        end
        S_CONFIRM_PRESS: begin
          if (!pressed_s) begin
            state_d = S_RELEASED;
            cnt_d   = 4'd0;
          end else if (cnt_q + 4'd1 == STABLE_N) begin
            state_d = S_PRESSED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_PRESSED: begin
          if (!pressed_s) begin
            state_d = S_CONFIRM_RELEASE;
            cnt_d   = 4'd1;
          end
        end
        S_CONFIRM_RELEASE: begin
          if (pressed_s) begin
            state_d = S_PRESSED;
            cnt_d   = 4'd0;
          end else if (cnt_q + 4'd1 == STABLE_N) begin
            state_d = S_RELEASED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_RELEASED;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Output logic: next values of the registered outputs and the hold counter.
  always_comb begin
    accept_press   = tick && (state_q == S_CONFIRM_PRESS) && (state_d == S_PRESSED);
    accept_release = tick && (state_q == S_CONFIRM_RELEASE) && (state_d == S_RELEASED);
    hold_run       = tick && ((state_q == S_PRESSED) || (state_q == S_CONFIRM_RELEASE));

    hold_cnt_d = hold_cnt_q;
    if (accept_press) begin
      hold_cnt_d = 10'd0;
    end else if (hold_run && (hold_cnt_q < HOLD_N)) begin
      hold_cnt_d = hold_cnt_q + 10'd1;
    end
    hold_reached = hold_run && (hold_cnt_d == HOLD_N);

    level_d   = (state_d == S_PRESSED) || (state_d == S_CONFIRM_RELEASE);
    press_d   = accept_press;
    release_d = accept_release;
    // A bounce back to PRESSED keeps held; only an accepted release clears it.
    held_d    = accept_release ? 1'b0 : (held | hold_reached);
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_debounce_button.sv
// Self-checking bench for debounce_button: directed scenarios plus random
// bursts, every cycle compared against a run-length reference model.
module tb_debounce_button;

  localparam int N = 4;
  localparam int H = 250;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       button_raw = 1'b1;
  logic       button_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       held;
  logic [1:0] state_dbg;

  int n_total = 0;
  int n_bad = 0;

  // Reference model: last two raw samples, accepted level, length of the
  // current run of samples disagreeing with it, ticks spent pressed.
  logic m_sq1, m_sq2, m_level, m_press, m_release, m_held;
  int   m_run, m_hold;

  int       press_seen, release_seen;
  int       first_press_tick, first_release_tick, first_held_tick;
  logic     held_prev;
  logic [3:0] release_outs;
  int       acc;
  int       b_period, b_len;
  logic     b_raw;

  always #5 clk_in = ~clk_in;

  debounce_button #(
    .STABLE_SAMPLES(N),
    .HOLD_TICKS(H),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .tick(tick),
    .button_raw(button_raw),
    .button_level(button_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .held(held),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {button_level, press_pulse, release_pulse, held};
  endfunction

  task automatic model_reset();
    m_sq1 = 1'b1;
    m_sq2 = 1'b1;
    m_level = 1'b0;
    m_press = 1'b0;
    m_release = 1'b0;
    m_held = 1'b0;
    m_run = 0;
    m_hold = 0;
  endtask

  task automatic model_step(input logic r, input logic t);
    logic ps;
    ps = ~m_sq2;
    m_sq2 = m_sq1;
    m_sq1 = r;
    m_press = 1'b0;
    m_release = 1'b0;
    if (t) begin
      if (m_level) begin
        if (m_hold < H) m_hold++;
        if (m_hold == H) m_held = 1'b1;
      end
      if (ps != m_level) begin
        m_run++;
        if (m_run == N) begin
          m_run = 0;
          m_level = ps;
          if (ps) begin
            m_press = 1'b1;
            m_hold = 0;
          end else begin
            m_release = 1'b1;
            m_held = 1'b0;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic t);
    button_raw = r;
    tick = t;
    @(posedge clk_in);
    #1;
    model_step(r, t);
    check("outs", outs(), {m_level, m_press, m_release, m_held});
  endtask

  task automatic observe(input int k);
    if (press_pulse) begin
      press_seen++;
      if (first_press_tick == 0) first_press_tick = k;
    end
    if (release_pulse) begin
      release_seen++;
      if (first_release_tick == 0) begin
        first_release_tick = k;
        release_outs = outs();
      end
    end
    if (held && !held_prev && first_held_tick == 0) first_held_tick = k;
    held_prev = held;
  endtask

  // Drives a steady raw level for nticks ticks, one tick every period cycles.
  task automatic run_ticks(input logic r, input int period, input int nticks);
    press_seen = 0;
    release_seen = 0;
    first_press_tick = 0;
    first_release_tick = 0;
    first_held_tick = 0;
    release_outs = 4'h0;
    held_prev = held;
    for (int k = 1; k <= nticks; k++) begin
      for (int i = 0; i < period - 1; i++) begin
        cycle(r, 1'b0);
        observe(k);
      end
      cycle(r, 1'b1);
      observe(k);
    end
  endtask

  task automatic pulse_reset(input logic r, input int cycles);
    button_raw = r;
    tick = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_async", outs(), 4'h0);
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in);
      #1;
      check("rst_hold", outs(), 4'h0);
    end
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_outs", outs(), 4'h0);
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b1;

    // Steady press with ticks every 10 cycles.
    run_ticks(1'b1, 10, 3);
    check("idle_no_press", press_seen, 0);
    run_ticks(1'b0, 10, 6);
    check("press_tick", first_press_tick, 4);
    check("press_once", press_seen, 1);
    check("press_level", button_level, 1);
    run_ticks(1'b1, 10, 4);
    check("release_tick", first_release_tick, 4);

    // Bounce: 3 pressed ticks, 1 released, then 4 pressed.
    run_ticks(1'b0, 10, 3);
    acc = press_seen + release_seen;
    run_ticks(1'b1, 10, 1);
    acc += press_seen + release_seen;
    check("bounce_no_pulse", acc, 0);
    run_ticks(1'b0, 10, 4);
    check("bounce_press_tick", first_press_tick, 4);
    check("bounce_press_once", press_seen, 1);

    // Long press then release.
    run_ticks(1'b0, 1, 260);
    check("held_tick", first_held_tick, 250);
    run_ticks(1'b1, 10, 4);
    check("held_release_tick", first_release_tick, 4);
    check("held_release_outs", release_outs, 4'b0010);

    // Release bounce at hold_cnt=100 must not restart the hold count.
    run_ticks(1'b0, 10, 4);
    run_ticks(1'b0, 1, 100);
    acc = press_seen + release_seen;
    run_ticks(1'b1, 10, 2);
    acc += press_seen + release_seen;
    run_ticks(1'b0, 10, 2);
    acc += press_seen + release_seen;
    run_ticks(1'b0, 1, 160);
    acc += press_seen + release_seen;
    check("rebounce_no_pulse", acc, 0);
    check("rebounce_held_tick", first_held_tick, 146);
    run_ticks(1'b1, 10, 4);
    check("rebounce_release", release_seen, 1);

    // Reset while held, key kept pressed.
    run_ticks(1'b0, 10, 4);
    run_ticks(1'b0, 1, 255);
    check("pre_reset_held", held, 1);
    pulse_reset(1'b0, 3);
    run_ticks(1'b0, 10, 6);
    check("post_reset_press_tick", first_press_tick, 4);
    check("post_reset_release", release_seen, 0);
    run_ticks(1'b1, 10, 4);

    // tick tied high: 3-cycle glitch, then a clean 6-cycle press.
    run_ticks(1'b0, 1, 3);
    acc = press_seen;
    run_ticks(1'b1, 1, 10);
    acc += press_seen;
    check("glitch_no_press", acc, 0);
    run_ticks(1'b0, 1, 6);
    acc = press_seen;
    run_ticks(1'b1, 1, 10);
    acc += press_seen;
    check("clean_one_press", acc, 1);

    // Random bursts against the model.
    for (int b = 0; b < 200; b++) begin
      b_period = $urandom_range(1, 3);
      b_len = $urandom_range(1, 8);
      b_raw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 19))
        0: run_ticks(1'b0, 1, $urandom_range(240, 300));
        1: pulse_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        2, 3: begin
          for (int i = 0; i < b_len * 3; i++) cycle(b_raw, 1'($urandom_range(0, 1)));
        end
        default: run_ticks(b_raw, b_period, b_len);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
